shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter WIDTH, default 64, datapath width; WIDTH SHALL be 64 (shift amount field is 6 bits).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 presents an operation.
REQ-005 req0_data  input  64  requester 0 operand.
REQ-006 req0_shamt  input  64  requester 0 shift amount; only bits [5:0] used.
REQ-007 req0_op  input  2  requester 0 op: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-008 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-009 req1_valid, req1_data, req1_shamt, req1_op, req1_ready: same widths/meanings for requester 1.
REQ-010 out_valid  output  1  result register holds a valid result.
REQ-011 out_data  output  64  shifted result.
REQ-012 out_id  output  1  index of requester owning out_data.
REQ-013 out_ready  input  1  consumer accepts result when high with out_valid.

Function
REQ-014 Block SHALL own one shared left barrel shifter (log-stage, 6 mux stages) and SHALL time-multiplex it between requesters.
REQ-015 Shift amount SHALL be masked to [5:0]; e.g. shamt 65 behaves as 1.
REQ-016 SRL/SRA SHALL be realised by bit-reversing operand, left-shifting, bit-reversing result; SRA SHALL fill vacated MSBs with original bit 63.
REQ-017 ROL SHALL return (d << s) | (d >> (64-s)); s=0 returns d unchanged.
REQ-018 Two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-019 Accept condition: accept = (EMPTY or out_ready) and (req0_valid or req1_valid); at most one request accepted per cycle.
REQ-020 Arbitration SHALL be round-robin via 1-bit last_grant pointer: when both valid, grant requester != last_grant; when one valid, grant it.
REQ-021 last_grant SHALL update to granted index only on accept.
REQ-022 reqN_ready SHALL be combinational: high only for granted requester in an accept cycle; never both high.
REQ-023 Latency: operation accepted at edge N SHALL appear on out_data/out_id with out_valid=1 after edge N (visible cycle N+1).
REQ-024 FULL and out_ready=0: out_data, out_id, out_valid SHALL hold; no ready asserted.
REQ-025 FULL and out_ready=1 with a pending request: result retired and new result loaded same edge (back-to-back, one result per cycle).
REQ-026 FULL and out_ready=1 with no request: transition to EMPTY.
REQ-027 EMPTY with no request: remain EMPTY; out_data unchanged.
REQ-028 Requester inputs SHALL be sampled only on its accept edge; changes afterwards SHALL not affect the registered result.
REQ-029 Requesters may drop valid without handshake; no request SHALL be latched unless accepted.

Reset
REQ-030 rst high SHALL immediately force out_valid=0, out_data=0, out_id=0, last_grant=1 (requester 0 wins first tie), state EMPTY.
REQ-031 While rst high, req0_ready and req1_ready SHALL be 0.
REQ-032 rst asserted mid-operation SHALL discard the held result; no result SHALL be emitted for it after release.
REQ-033 First accept SHALL be possible on first rising edge after rst deasserts.

Verification
REQ-034 Single SLL: req0 data=0x1, shamt=13, op=00, out_ready=1 -> next cycle out_valid=1, out_data=0x2000, out_id=0.
REQ-035 Mask/SRA: req1 data=0x8000_0000_0000_0000, shamt=65, op=10 -> out_data=0xC000_0000_0000_0000, out_id=1; op=01 same inputs -> 0x4000_0000_0000_0000.
REQ-036 ROL: data=0xF0F0_F0F0_F0F0_F0F0, shamt=4, op=11 -> 0x0F0F_0F0F_0F0F_0F0F; shamt=0 -> unchanged.
REQ-037 Contention: both valid continuously after reset, out_ready=1 -> grants alternate 0,1,0,1; one result per cycle; out_id matches.
REQ-038 Backpressure: out_ready=0 for 3 cycles while FULL, both valid -> out_data/out_id stable, both ready=0; out_ready=1 -> retire and load next same edge.
REQ-039 Reset mid-stream: assert rst while FULL -> out_valid=0, out_data=0 immediately; after release, tie goes to requester 0.

Source files
------------

// File: rtl/shift_arbiter.sv
// Two-requester shift unit. One shared log-stage left barrel shifter is
// time-multiplexed between the requesters by a round-robin arbiter. The
// result goes into a single output register with a valid/ready handshake.
//
// state | meaning
// EMPTY | result register holds nothing, out_valid low
// FULL  | result register holds a result, out_valid high
module shift_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [WIDTH-1:0] req0_shamt,
  input  logic [1:0]       req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [WIDTH-1:0] req1_shamt,
  input  logic [1:0]       req1_op,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  input  logic             out_ready
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic [5:0]       sel_shamt;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] shift_result;
  logic             unused_shamt_hi;

  // Only the low six shift-amount bits matter; upper bits are ignored.
  assign unused_shamt_hi = ^{req0_shamt[WIDTH-1:6], req1_shamt[WIDTH-1:6], OP_SLL};

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    return r;
  endfunction

  // Round-robin pick and accept; readies are held low during reset.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
    accept     = !rst && (state == EMPTY || out_ready) && (req0_valid || req1_valid);
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
  end

  // Steer the granted requester's operands into the shared shifter.
  always_comb begin
    sel_data  = grant ? req1_data        : req0_data;
    sel_shamt = grant ? req1_shamt[5:0]  : req0_shamt[5:0];
    sel_op    = grant ? req1_op          : req0_op;
  end

  // Shared left shifter; right shifts wrap it in bit reversal, SRA feeds the
  // sign bit in as fill, ROL feeds the bits shifted out back in at the bottom.
  always_comb begin
    logic             reverse;
    logic             rotate;
    logic             fill;
    logic [WIDTH-1:0] stage;
    reverse = (sel_op == OP_SRL) || (sel_op == OP_SRA);
    rotate  = (sel_op == OP_ROL);
    fill    = (sel_op == OP_SRA) && sel_data[WIDTH-1];
    stage   = reverse ? bit_rev(sel_data) : sel_data;
    for (int k = 0; k < 6; k++) begin
      if (sel_shamt[k]) begin
        if (rotate)
          stage = (stage << (1 << k)) | (stage >> (WIDTH - (1 << k)));
        else
          stage = (stage << (1 << k)) | (fill ? ~(ALL_ONES << (1 << k)) : '0);
      end
    end
    shift_result = reverse ? bit_rev(stage) : stage;
  end

  // Result register FSM: load on accept, drain to EMPTY when consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      out_data   <= '0;
      out_id     <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_data   <= shift_result;
            out_id     <= grant;
            last_grant <= grant;
            state      <= FULL;
          end
        end
        FULL: begin
          if (accept) begin
            out_data   <= shift_result;
            out_id     <= grant;
            last_grant <= grant;
          end else if (out_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with hand-computed expected values.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [63:0] req0_data, req0_shamt, req1_data, req1_shamt;
  logic [1:0]  req0_op, req1_op;
  logic        req0_ready, req1_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_id;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_arbiter #(.WIDTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_shamt (req0_shamt),
    .req0_op    (req0_op),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_shamt (req1_shamt),
    .req1_op    (req1_op),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation from a single requester, then its result one edge later.
  task automatic issue(input bit id, input logic [63:0] d, input logic [63:0] s,
                       input logic [1:0] op, input logic [63:0] exp, input string tag);
    if (id) begin
      req1_valid = 1'b1; req1_data = d; req1_shamt = s; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_shamt = s; req0_op = op;
    end
    #1;
    check({tag, "_ready0"}, 64'(req0_ready), 64'(!id));
    check({tag, "_ready1"}, 64'(req1_ready), 64'(id));
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    req1_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    req0_shamt = 64'd7; req1_shamt = 64'd7;
    #1;
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_id"},    64'(out_id),    64'(id));
    check({tag, "_data"},  out_data,       exp);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req0_shamt = '0; req0_op = 2'b00;
    req1_data = '0; req1_shamt = '0; req1_op = 2'b00;
    out_ready = 1'b0;

    // Reset state, readies forced low under reset even with valid requests
    #2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rst_valid",  64'(out_valid),  64'd0);
    check("rst_data",   out_data,        64'd0);
    check("rst_id",     64'(out_id),     64'd0);
    check("rst_ready0", 64'(req0_ready), 64'd0);
    check("rst_ready1", 64'(req1_ready), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;

    // Single requests, back-to-back, across all ops and shift boundaries
    issue(1'b0, 64'h1,                   64'd13, 2'b00, 64'h0000_0000_0000_2000, "sll13");
    issue(1'b1, 64'h8000_0000_0000_0000, 64'd65, 2'b10, 64'hC000_0000_0000_0000, "sra65");
    issue(1'b1, 64'h8000_0000_0000_0000, 64'd65, 2'b01, 64'h4000_0000_0000_0000, "srl65");
    issue(1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'd4,  2'b11, 64'h0F0F_0F0F_0F0F_0F0F, "rol4");
    issue(1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'd0,  2'b11, 64'hF0F0_F0F0_F0F0_F0F0, "rol0");
    issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd63, 2'b01, 64'h0000_0000_0000_0001, "srl63");
    issue(1'b1, 64'h7000_0000_0000_0000, 64'd4,  2'b10, 64'h0700_0000_0000_0000, "sra_pos");
    issue(1'b0, 64'h5,                   64'd64, 2'b00, 64'h5,                   "sll64");

    // Drain with no request: back to EMPTY, data kept
    tick();
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_data",  out_data,       64'h5);
    tick();
    check("idle_valid",  64'(out_valid), 64'd0);

    // Fresh reset, then continuous contention
    rst = 1'b1;
    #2;
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 64'h1; req0_shamt = 64'd1; req0_op = 2'b00;
    req1_valid = 1'b1; req1_data = 64'h1; req1_shamt = 64'd2; req1_op = 2'b00;
    tick();
    check("cont0_valid", 64'(out_valid), 64'd1);
    check("cont0_id",    64'(out_id),    64'd0);
    check("cont0_data",  out_data,       64'h2);
    for (int i = 1; i < 4; i++) begin
      bit g;
      g = (i % 2 == 1);
      check("cont_ready0", 64'(req0_ready), 64'(!g));
      check("cont_ready1", 64'(req1_ready), 64'(g));
      tick();
      check("cont_valid", 64'(out_valid), 64'd1);
      check("cont_id",    64'(out_id),    64'(g));
      check("cont_data",  out_data,       g ? 64'h4 : 64'h2);
    end

    // Backpressure with both requesting: everything holds
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready0", 64'(req0_ready), 64'd0);
      check("bp_ready1", 64'(req1_ready), 64'd0);
      tick();
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_id",    64'(out_id),    64'd1);
      check("bp_data",  out_data,       64'h4);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_ready0", 64'(req0_ready), 64'd1);
    check("bp_rel_ready1", 64'(req1_ready), 64'd0);
    tick();
    check("bp_rel_id",   64'(out_id), 64'd0);
    check("bp_rel_data", out_data,    64'h2);

    // Reset while FULL clears immediately, no stale result afterwards
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid",  64'(out_valid),  64'd0);
    check("mid_rst_data",   out_data,        64'd0);
    check("mid_rst_ready0", 64'(req0_ready), 64'd0);
    check("mid_rst_ready1", 64'(req1_ready), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    rst = 1'b0;
    tick();
    check("post_rst_valid", 64'(out_valid), 64'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("post_rst_ready0", 64'(req0_ready), 64'd1);
    check("post_rst_ready1", 64'(req1_ready), 64'd0);
    tick();
    check("post_rst_id",   64'(out_id),    64'd0);
    check("post_rst_data", out_data,       64'h2);
    check("post_rst_out",  64'(out_valid), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
